interval_timer_arbiter: RTL and testbench

- Shares one 8-bit up-counter among NREQ requesters that each need a timed interval of N clock cycles.
- Round-robin arbitration picks one requester, latches its length, and sequences the counter through clear and count.
- Pulses done to the winner when the interval expires.
- Sits beside the mapped counter datapath as its scheduler; the counter is instantiated inside as a sub-module.

---
 rtl/timer_arb_pkg.sv | 32 +++
 rtl/interval_counter.sv | 33 +++
 rtl/interval_timer_arbiter.sv | 121 ++++++++++++
 tb/tb_interval_timer_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the interval timer arbiter.
// Holds the FSM encoding, default sizes and the round-robin picker.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  // First set bit at or above ptr, wrapping modulo n (n <= 8).
  function automatic logic [2:0] rr_pick(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] pick;
    int         idx;
    pick = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// Clearable up-counter shared by all requesters.
// hit flags the cycle whose increment reaches the latched length.
module interval_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_len,
  output logic [WIDTH-1:0] o_count,
  output logic             o_hit
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   ONEX = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;
  assign o_hit   = ({1'b0, r_count} + ONEX) == {1'b0, i_len};

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin scheduler that lends one interval counter to NREQ requesters.
// Grants, times the winner's latched length, and pulses done on expiry.
module interval_timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam logic [NREQ-1:0] ONEHOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nx;
  logic [NREQ-1:0]  r_gnt, w_gnt_nx;
  logic [2:0]       r_win, w_win_nx;
  logic [2:0]       r_ptr, w_ptr_nx;
  logic [WIDTH-1:0] r_len_q, w_len_nx;
  logic [WIDTH-1:0] w_len_sel;
  logic [2:0]       w_pick, w_next_ptr;
  logic [7:0]       w_req8;
  logic             w_any, w_abort, w_hit;
  logic             w_clr, w_en;

  assign w_req8     = 8'(req);
  assign w_any      = |req;
  assign w_pick     = rr_pick(w_req8, r_ptr, NREQ);
  assign w_abort    = (r_state == RUN) && !w_req8[r_win];
  assign w_next_ptr = (r_win == 3'(NREQ-1)) ? 3'd0 : r_win + 3'd1;

  always_comb begin
    w_len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == 3'(i)) w_len_sel = req_len[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_win_nx   = r_win;
    w_ptr_nx   = r_ptr;
    w_len_nx   = r_len_q;
    w_clr      = 1'b0;
    w_en       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (w_any) begin
          w_gnt_nx   = ONEHOT0 << w_pick;
          w_win_nx   = w_pick;
          w_len_nx   = w_len_sel;
          w_state_nx = (w_len_sel != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // A dropped request beats the terminal count.
        if (w_abort) begin
          w_state_nx = IDLE;
          w_gnt_nx   = '0;
          w_ptr_nx   = w_next_ptr;
          w_clr      = 1'b1;
        end else begin
          w_en = 1'b1;
          if (w_hit) w_state_nx = DONE;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
        w_ptr_nx   = w_next_ptr;
        w_clr      = 1'b1;
      end
      default: begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
        w_clr      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_win   <= '0;
      r_ptr   <= '0;
      r_len_q <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_win   <= w_win_nx;
      r_ptr   <= w_ptr_nx;
      r_len_q <= w_len_nx;
    end
  end

  interval_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_len   (r_len_q),
    .o_count (count),
    .o_hit   (w_hit)
  );

  assign gnt  = r_gnt;
  assign done = (r_state == DONE) ? r_gnt : '0;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter: a per-cycle vector table
// plus short hand sequences for abort, async reset and collisions.
module tb_interval_timer_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_len = '0;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [7:0]  count;

  always #5 clk = ~clk;

  interval_timer_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .count   (count)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void add(
    input logic rs, input logic [3:0] rq, input logic [31:0] ln,
    input logic [3:0] g, input logic [3:0] d, input logic b,
    input logic [7:0] c
  );
    vec_t v;
    v.rst_n = rs; v.req = rq; v.len = ln;
    v.gnt = g; v.done = d; v.busy = b; v.cnt = c;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string t, input logic [3:0] g,
                      input logic [3:0] d, input logic b,
                      input logic [7:0] c);
    chk({t, "_gnt"},   32'(gnt),   32'(g));
    chk({t, "_done"},  32'(done),  32'(d));
    chk({t, "_busy"},  32'(busy),  32'(b));
    chk({t, "_count"}, 32'(count), 32'(c));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    req_len = '0;
    cyc();
    reset_n = 1'b1;
  endtask

  localparam logic [31:0] L1 = 32'h0000_0300;
  localparam logic [31:0] LR = 32'h0202_0202;

  initial begin
    logic [3:0] own;
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;

    add(1, 4'b0010, L1, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0010, L1, 4'b0010, 4'b0000, 1, 0);
    add(1, 4'b0010, L1, 4'b0010, 4'b0000, 1, 1);
    add(1, 4'b0010, L1, 4'b0010, 4'b0000, 1, 2);
    add(1, 4'b0000, L1, 4'b0010, 4'b0010, 1, 3);
    add(1, 4'b0100, 0,  4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 0,  4'b0100, 4'b0100, 1, 0);
    add(0, 4'b0000, 0,  4'b0000, 4'b0000, 0, 0);
    for (int g = 0; g < 4; g++) begin
      own = 4'b0001 << g;
      add(1, 4'b1111, LR, 4'b0000, 4'b0000, 0, 0);
      add(1, 4'b1111, LR, own, 4'b0000, 1, 0);
      add(1, 4'b1111, LR, own, 4'b0000, 1, 1);
      add(1, 4'b1111, LR, own, own, 1, 2);
    end
    add(1, 4'b1111, LR, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, LR, 4'b0001, 4'b0000, 1, 0);
    add(1, 4'b0000, LR, 4'b0000, 4'b0000, 0, 0);

    foreach (vq[i]) begin
      chk4($sformatf("row%0d", i), vq[i].gnt, vq[i].done,
           vq[i].busy, vq[i].cnt);
      reset_n = vq[i].rst_n;
      req     = vq[i].req;
      req_len = vq[i].len;
      cyc();
    end

    do_reset();
    req = 4'b1001;
    req_len = 32'h0100_000A;
    cyc();
    chk4("abort_gnt", 4'b0001, 4'b0000, 1, 0);
    req_len = 32'h0100_0002;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk4($sformatf("abort_run%0d", k), 4'b0001, 4'b0000, 1, 8'(k));
    end
    req = 4'b1000;
    cyc();
    chk4("abort_idle", 4'b0000, 4'b0000, 0, 0);
    cyc();
    chk4("abort_next", 4'b1000, 4'b0000, 1, 0);
    req = 4'b0000;
    cyc();
    chk4("coll1_idle", 4'b0000, 4'b0000, 0, 0);

    do_reset();
    req = 4'b0100;
    req_len = 32'h000A_0000;
    cyc();
    for (int k = 1; k <= 5; k++) cyc();
    chk4("rst_pre", 4'b0100, 4'b0000, 1, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk4("rst_async", 4'b0000, 4'b0000, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    chk4("rst_regrant", 4'b0100, 4'b0000, 1, 0);
    req = 4'b0000;
    cyc();
    chk4("rst_drop", 4'b0000, 4'b0000, 0, 0);

    do_reset();
    req = 4'b0010;
    req_len = L1;
    cyc();
    cyc();
    cyc();
    chk4("coll_c2", 4'b0010, 4'b0000, 1, 2);
    req = 4'b0000;
    cyc();
    chk4("coll_abort", 4'b0000, 4'b0000, 0, 0);
    cyc();
    chk4("coll_after", 4'b0000, 4'b0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
